// File: rtl/mini_alu_arbiter.sv
// Round-robin owner of a shared 4-bit miniALU: one job in flight, result tagged with requester index.
// Optional ALU_STATS_EN adds stat_clr / stat_count saturating per-requester job counters.
module mini_alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1,
   parameter int STAT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [4*NUM_REQ-1:0]   req_op1,
   input  logic [4*NUM_REQ-1:0]   req_op2,
   input  logic [NUM_REQ-1:0]     req_operation,
   input  logic [NUM_REQ-1:0]     req_sign,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [19:0]            resp_result
`ifdef ALU_STATS_EN
   ,
   input  logic                   stat_clr,
   output logic [STAT_W*NUM_REQ-1:0] stat_count
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] grant_id;
   logic            grant_any;
   logic            accept;
   int              cand;

   logic [3:0]      op1_p0, op2_p0;
   logic            operation_p0, sign_p0;
   logic [3:0]      op1_sel, op2_sel;
   logic            operation_sel, sign_sel;

   function automatic logic [19:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic op, input logic sgn);
      logic [19:0] ae;
      logic [19:0] be;
      ae = {16'd0, a};
      be = {16'd0, b};
      case ({op, sgn})
         2'b00:   return ae + be;
         2'b01:   return ae - be;
         2'b10:   return ae << b;
         default: return ae >> b;
      endcase
   endfunction

   // Search begins just after the previous winner so it drops to lowest priority.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!grant_any && req_valid[ID_W'(cand)]) begin
            grant_any = 1'b1;
            grant_id  = ID_W'(cand);
         end
      end
   end

   always_comb begin
      op1_sel       = '0;
      op2_sel       = '0;
      operation_sel = 1'b0;
      sign_sel      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            op1_sel       = req_op1[4*i +: 4];
            op2_sel       = req_op2[4*i +: 4];
            operation_sel = req_operation[i];
            sign_sel      = req_sign[i];
         end
      end
   end

   // Reset is folded in so no accept strobe can leak out while rst_n is low.
   assign accept = rst_n && (state == IDLE) && grant_any;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = accept && (grant_id == ID_W'(i));
      end
   end

   // p0: operands latched at accept; result stage captured from them one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= ID_W'(NUM_REQ - 1);
         op1_p0       <= '0;
         op2_p0       <= '0;
         operation_p0 <= 1'b0;
         sign_p0      <= 1'b0;
         resp_valid   <= 1'b0;
         resp_id      <= '0;
         resp_result  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  op1_p0       <= op1_sel;
                  op2_p0       <= op2_sel;
                  operation_p0 <= operation_sel;
                  sign_p0      <= sign_sel;
                  last_grant   <= grant_id;
                  state        <= EXEC;
               end
            end
            EXEC: begin
               resp_result <= alu_f(op1_p0, op2_p0, operation_p0, sign_p0);
               resp_id     <= last_grant;
               resp_valid  <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_STATS_EN
   logic resp_hs;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign resp_hs = (state == RESP) && resp_valid && resp_ready;

   // Clear takes priority over a handshake in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_count <= '0;
      end else if (stat_clr) begin
         stat_count <= '0;
      end else if (resp_hs) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (resp_id == ID_W'(i))
               stat_count[STAT_W*i +: STAT_W] <= sat_inc(stat_count[STAT_W*i +: STAT_W]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mini_alu_arbiter.sv
// Directed bench for mini_alu_arbiter: ALU results, round-robin order, back-pressure, reset and stats.
module tb_mini_alu_arbiter;
   localparam int NUM_REQ = 2;
   localparam int ID_W    = 1;
   localparam int STAT_W  = 2;

   logic                   clk;
   logic                   rst_n;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [4*NUM_REQ-1:0]   req_op1;
   logic [4*NUM_REQ-1:0]   req_op2;
   logic [NUM_REQ-1:0]     req_operation;
   logic [NUM_REQ-1:0]     req_sign;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [ID_W-1:0]        resp_id;
   logic [19:0]            resp_result;
`ifdef ALU_STATS_EN
   logic                   stat_clr;
   logic [STAT_W*NUM_REQ-1:0] stat_count;
`endif

   int checks = 0;
   int fails  = 0;

   mini_alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .STAT_W(STAT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2),
      .req_operation(req_operation), .req_sign(req_sign),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_result(resp_result)
`ifdef ALU_STATS_EN
      , .stat_clr(stat_clr), .stat_count(stat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts and ends at a falling edge with the DUT idle.
   task automatic job(input int id, input logic [3:0] a, input logic [3:0] b,
                      input logic op, input logic sg, input logic [19:0] exp);
      logic [1:0] oh;
      oh = (id == 0) ? 2'b01 : 2'b10;
      req_op1[4*id +: 4]  = a;
      req_op2[4*id +: 4]  = b;
      req_operation[id]   = op;
      req_sign[id]        = sg;
      req_valid[id]       = 1'b1;
      resp_ready          = 1'b1;
      #1 chk("job_ready", 32'(req_ready), 32'(oh));
      @(negedge clk);
      req_valid[id] = 1'b0;
      chk("exec_ready", 32'(req_ready), 32'd0);
      chk("exec_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_id", 32'(resp_id), 32'(id));
      chk("resp_result", 32'(resp_result), 32'(exp));
      @(negedge clk);
      chk("resp_done", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [1:0] exp_oh;
      rst_n = 1'b0;
      req_valid = '0;
      req_op1 = '0;
      req_op2 = '0;
      req_operation = '0;
      req_sign = '0;
      resp_ready = 1'b0;
`ifdef ALU_STATS_EN
      stat_clr = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_id", 32'(resp_id), 32'd0);
      chk("rst_result", 32'(resp_result), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;

      // basic add, then the three other ALU modes
      job(0, 4'd7, 4'd5, 1'b0, 1'b0, 20'd12);
      job(1, 4'd3, 4'd5, 1'b0, 1'b1, 20'hFFFFE);
      job(0, 4'd15, 4'd15, 1'b1, 1'b0, 20'h78000);
      job(1, 4'd12, 4'd2, 1'b1, 1'b1, 20'd3);

      // both requesters continuously valid: strict alternation, 3 cycles apart
      req_op1 = {4'd2, 4'd1};
      req_op2 = {4'd2, 4'd2};
      req_operation = '0;
      req_sign = '0;
      req_valid = 2'b11;
      resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1 chk("rr_ready", 32'(req_ready), 32'(exp_oh));
         @(negedge clk);
         chk("rr_exec_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
         chk("rr_valid", 32'(resp_valid), 32'd1);
         chk("rr_id", 32'(resp_id), 32'(k % 2));
         chk("rr_result", 32'(resp_result), (k % 2 == 0) ? 32'd3 : 32'd4);
         @(negedge clk);
      end
      req_valid = 2'b00;

      // back-pressure on the response
      req_op1[7:4] = 4'd9;
      req_op2[7:4] = 4'd4;
      req_operation[1] = 1'b1;
      req_sign[1] = 1'b0;
      req_valid = 2'b10;
      resp_ready = 1'b0;
      #1 chk("bp_ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid = 2'b01;
      chk("bp_exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("bp_valid0", 32'(resp_valid), 32'd1);
      chk("bp_result0", 32'(resp_result), 32'h90);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(resp_valid), 32'd1);
         chk("bp_hold_id", 32'(resp_id), 32'd1);
         chk("bp_hold_result", 32'(resp_result), 32'h90);
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 32'(resp_valid), 32'd0);
      chk("bp_next_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      chk("bp_next_id", 32'(resp_id), 32'd0);
      chk("bp_next_result", 32'(resp_result), 32'd3);
      @(negedge clk);

      // reset in the middle of a job
      req_valid = 2'b01;
      #1;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 2'b10;
      #1;
      chk("mid_rst_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_id", 32'(resp_id), 32'd0);
      chk("mid_rst_result", 32'(resp_result), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("no_stale0", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("no_stale1", 32'(resp_valid), 32'd0);
      job(1, 4'd6, 4'd3, 1'b0, 1'b1, 20'd3);
      job(0, 4'd6, 4'd3, 1'b0, 1'b0, 20'd9);

      // pointer returns to NUM_REQ-1 on reset, so requester 0 wins a tie
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 2'b11;
      #1 chk("ptr_reset_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      chk("ptr_reset_id", 32'(resp_id), 32'd0);
      chk("ptr_reset_valid", 32'(resp_valid), 32'd1);
      @(negedge clk);

`ifdef ALU_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("stat_clr", 32'(stat_count), 32'd0);
      repeat (3) job(1, 4'd1, 4'd1, 1'b0, 1'b0, 20'd2);
      chk("stat_req1_3", 32'(stat_count[3:2]), 32'd3);
      chk("stat_req0_0", 32'(stat_count[1:0]), 32'd0);
      repeat (2) job(1, 4'd1, 4'd1, 1'b0, 1'b0, 20'd2);
      chk("stat_sat", 32'(stat_count[3:2]), 32'd3);
      req_valid[1] = 1'b1;
      #1;
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("stat_hs_valid", 32'(resp_valid), 32'd1);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      chk("stat_clr_wins", 32'(stat_count), 32'd0);
      chk("stat_hs_done", 32'(resp_valid), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
